// File: rtl/itlb_walker_pkg.sv
// Shared types and constants for the Sv39 instruction-side page table walker.
package itlb_walker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DONE,
        ST_DRAIN
    } walk_state_e;

    localparam logic [3:0] SATP_MODE_BARE = 4'h0;
    localparam logic [3:0] SATP_MODE_SV39 = 4'h8;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;
    localparam int PPN_W       = PTE_PPN_MSB - PTE_PPN_LSB + 1;

    localparam logic [1:0] LEVEL_ROOT = 2'd2;

    function automatic logic [8:0] vpn_sel(input logic [63:0] va, input logic [1:0] level);
        case (level)
            2'd2:    return va[38:30];
            2'd1:    return va[29:21];
            default: return va[20:12];
        endcase
    endfunction

endpackage

// File: rtl/itlb_walker_if.sv
// Translation request/response and PTE memory read signals of the walker.
interface itlb_walker_if;
    logic        tr_req;
    logic [63:0] tr_vaddr;
    logic        tr_done;
    logic [63:0] tr_paddr;
    logic        tr_fault;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ok;
    logic [63:0] mem_rdata;

    modport master (
        input  tr_req, tr_vaddr, mem_ok, mem_rdata,
        output tr_done, tr_paddr, tr_fault, mem_req, mem_addr
    );

    modport slave (
        output tr_req, tr_vaddr, mem_ok, mem_rdata,
        input  tr_done, tr_paddr, tr_fault, mem_req, mem_addr
    );
endinterface

// File: rtl/itlb_pte_check.sv
// Combinational PTE classification: leaf/pointer, page fault and final physical address.
// Superpage leaves are translated only when ITLB_SUPERPAGE_EN is defined.
module itlb_pte_check
    import itlb_walker_pkg::*;
(
    input  logic [63:0] i_pte,
    input  logic [1:0]  i_level,
    input  logic [63:0] i_vaddr,
    output logic        o_is_leaf,
    output logic        o_fault,
    output logic [63:0] o_paddr
);

    logic             w_v;
    logic             w_r;
    logic             w_w;
    logic             w_x;
    logic [PPN_W-1:0] w_ppn;
    logic             w_unused;

    assign w_v      = i_pte[PTE_V];
    assign w_r      = i_pte[PTE_R];
    assign w_w      = i_pte[PTE_W];
    assign w_x      = i_pte[PTE_X];
    assign w_ppn    = i_pte[PTE_PPN_MSB:PTE_PPN_LSB];
    assign w_unused = ^{i_pte[63:54], i_pte[9:4], i_vaddr[63:12]};

    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        o_is_leaf = w_r | w_x;
        o_fault   = 1'b0;
        o_paddr   = {8'b0, w_ppn, i_vaddr[11:0]};
        if (!w_v || (!w_r && w_w)) begin
            o_fault = 1'b1;
        end else if (!(w_r | w_x)) begin
            o_fault = (i_level == 2'd0);
        end else if (!w_x) begin
            o_fault = 1'b1;
        end else begin
            case (i_level)
                2'd0: o_fault = 1'b0;
`ifdef ITLB_SUPERPAGE_EN
                2'd1: begin
                    o_paddr = {8'b0, w_ppn[43:9], i_vaddr[20:0]};
                    o_fault = |w_ppn[8:0];
                end
                2'd2: begin
                    o_paddr = {8'b0, w_ppn[43:18], i_vaddr[29:0]};
                    o_fault = |w_ppn[17:0];
                end
`endif
                default: o_fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/itlb_walker.sv
// Sv39 instruction TLB miss walker: three-level PTE walk with flush/drain handling.
// Optional superpage leaves at levels 1/2 via macro ITLB_SUPERPAGE_EN (in itlb_pte_check).
module itlb_walker
    import itlb_walker_pkg::*;
#(
    parameter int unsigned PTE_BYTES = 8,
    parameter logic [3:0]  SV39_MODE = SATP_MODE_SV39
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   satp,
    input  logic          flush,
    output logic          busy,
    itlb_walker_if.master bus
);

    walk_state_e r_state;
    logic [1:0]  r_level;
    logic [63:0] r_va;
    logic        r_mem_req;
    logic [63:0] r_mem_addr;
    logic        r_tr_done;
    logic [63:0] r_tr_paddr;
    logic        r_tr_fault;
    logic        r_busy;

    logic        w_is_leaf;
    logic        w_fault;
    logic [63:0] w_paddr;
    logic [3:0]  w_mode;
    logic        w_unused;

    assign w_mode   = satp[63:60];
    assign w_unused = ^satp[59:44];

    function automatic logic [63:0] pte_addr(input logic [PPN_W-1:0] ppn,
                                             input logic [63:0] va,
                                             input logic [1:0] level);
        return {8'b0, ppn, 12'b0} + 64'(vpn_sel(va, level)) * 64'(PTE_BYTES);
    endfunction

    itlb_pte_check u_pte_check (
        .i_pte     (bus.mem_rdata),
        .i_level   (r_level),
        .i_vaddr   (r_va),
        .o_is_leaf (w_is_leaf),
        .o_fault   (w_fault),
        .o_paddr   (w_paddr)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_level    <= LEVEL_ROOT;
            r_va       <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_tr_done  <= 1'b0;
            r_tr_paddr <= '0;
            r_tr_fault <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.tr_req && !flush) begin
                        r_busy <= 1'b1;
                        if (w_mode == SATP_MODE_BARE) begin
                            r_state    <= ST_DONE;
                            r_tr_done  <= 1'b1;
                            r_tr_paddr <= bus.tr_vaddr;
                            r_tr_fault <= 1'b0;
                        end else if (w_mode == SV39_MODE) begin
                            r_state    <= ST_WALK;
                            r_va       <= bus.tr_vaddr;
                            r_level    <= LEVEL_ROOT;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= pte_addr(satp[PPN_W-1:0], bus.tr_vaddr, LEVEL_ROOT);
                        end else begin
                            r_state    <= ST_DONE;
                            r_tr_done  <= 1'b1;
                            r_tr_paddr <= '0;
                            r_tr_fault <= 1'b1;
                        end
                    end
                end
                ST_WALK: begin
                    if (bus.mem_ok) begin
                        if (flush) begin
                            r_state   <= ST_IDLE;
                            r_mem_req <= 1'b0;
                            r_busy    <= 1'b0;
                            r_level   <= LEVEL_ROOT;
                        end else if (w_fault || w_is_leaf) begin
                            r_state    <= ST_DONE;
                            r_mem_req  <= 1'b0;
                            r_tr_done  <= 1'b1;
                            r_tr_fault <= w_fault;
                            r_tr_paddr <= w_fault ? 64'd0 : w_paddr;
                        end else begin
                            // Pointer PTE: descend one level and re-issue at the child table.
                            r_level    <= r_level - 2'd1;
                            r_mem_addr <= pte_addr(bus.mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB],
                                                   r_va, r_level - 2'd1);
                        end
                    end else if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_level <= LEVEL_ROOT;
                end
                ST_DRAIN: begin
                    if (bus.mem_ok) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_level   <= LEVEL_ROOT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A flush arriving while the result is presented cancels the pulse in that same cycle.
    assign bus.tr_done  = r_tr_done && !flush;
    assign bus.tr_paddr = r_tr_paddr;
    assign bus.tr_fault = r_tr_fault;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign busy         = r_busy;

endmodule
